// File: rtl/spi_pkg.sv
// spi_pkg
//   Types and defaults shared by the SPI transmit engine and the SPI slave
//   receiver.
//   - spi_tx_state_e           : transmit FSM state encoding
//   - SPI_CLOCK_SCALE_DEFAULT  : default number of system clocks per SCLK period
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_tx_state_e;

    localparam int unsigned SPI_CLOCK_SCALE_DEFAULT = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
//   Half-period timebase and SCLK generator for the SPI transmit engine.
//   The half-period counter runs whenever the engine is busy, so SETUP, every
//   SCLK half-period and HOLD all end on the same wrap pulse.
//   Ports:
//     clk_i, rst_ni  : system clock, asynchronous active-low reset
//     en_i           : engine busy; counter and SCLK held at rest when low
//     shift_next_i   : the engine will be shifting in the next cycle
//     wrap_o         : last cycle of the current half-period
//     lead_o         : the coming clock edge produces an SCLK leading edge
//     trail_o        : the coming clock edge produces an SCLK trailing edge
//     sclk_o         : SCLK, idles at CPOL
module spi_sclk_gen #(
    parameter int unsigned Half = 4,
    parameter bit          CPOL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic shift_next_i,
    output logic wrap_o,
    output logic lead_o,
    output logic trail_o,
    output logic sclk_o
);

    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
    localparam logic [CntW-1:0] HalfMax = CntW'(Half - 1);

    logic [CntW-1:0] hcnt_q;
    logic            sclk_q;
    logic            toggle;

    assign wrap_o  = en_i && (hcnt_q == HalfMax);
    // SCLK only moves at a half-period boundary that leads into (more) shifting,
    // so it rests at CPOL through SETUP and HOLD.
    assign toggle  = wrap_o && shift_next_i;
    assign lead_o  = toggle && (sclk_q == CPOL);
    assign trail_o = toggle && (sclk_q != CPOL);
    assign sclk_o  = sclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q <= '0;
            sclk_q <= CPOL;
        end else if (!en_i) begin
            hcnt_q <= '0;
            sclk_q <= CPOL;
        end else begin
            hcnt_q <= wrap_o ? '0 : hcnt_q + 1'b1;
            if (toggle) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_tx_engine.sv
// spi_tx_engine
//   SPI master transmitter: pops bytes from an upstream FIFO and shifts them
//   out MSB first. Consecutive bytes are streamed with CS held low and SCLK
//   running continuously; an empty FIFO at the end of a byte closes the frame.
//   Ports:
//     clk_i, rst_ni   : system clock, asynchronous active-low reset
//     fifo_rvalid_i   : FIFO holds a byte
//     fifo_rdata_i    : FIFO head byte
//     fifo_rready_o   : single-cycle pop strobe
//     spi_mosi_o      : serial data, MSB first, 0 when idle
//     spi_clk_o       : SCLK (idles at CPOL)
//     spi_cs_o        : chip select, active-low
//     busy_o          : high whenever the FSM is not IDLE
module spi_tx_engine
    import spi_pkg::*;
#(
    parameter int unsigned SPIClockScale = SPI_CLOCK_SCALE_DEFAULT,
    parameter bit          CPOL          = 1'b0,
    parameter bit          CPHA          = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fifo_rvalid_i,
    input  logic [7:0] fifo_rdata_i,
    output logic       fifo_rready_o,
    output logic       spi_mosi_o,
    output logic       spi_clk_o,
    output logic       spi_cs_o,
    output logic       busy_o
);

    localparam int unsigned Half = SPIClockScale / 2;

    spi_tx_state_e state_q, state_d;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          mosi_q;

    logic pop;
    logic pop_in_shift;
    logic last_shift;
    logic wrap;
    logic lead;
    logic trail;
    logic advance;

    spi_sclk_gen #(
        .Half (Half),
        .CPOL (CPOL)
    ) u_sclk_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (state_q != ST_IDLE),
        .shift_next_i (state_d == ST_SHIFT),
        .wrap_o       (wrap),
        .lead_o       (lead),
        .trail_o      (trail),
        .sclk_o       (spi_clk_o)
    );

    // Eight trailing edges have passed once bit_cnt reaches 8; the wrap of the
    // following (final) half-period is the last SHIFT cycle of the byte.
    assign last_shift   = (state_q == ST_SHIFT) && wrap && (bit_cnt_q == 4'd8);
    assign pop_in_shift = pop && (state_q == ST_SHIFT);
    assign advance      = CPHA ? lead : trail;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_rvalid_i) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (wrap) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    if (fifo_rvalid_i) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            mosi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                bit_cnt_q <= 4'd0;
                // CPHA=1 from IDLE keeps MOSI quiet until the first leading
                // edge; when streaming, that leading edge coincides with the pop.
                mosi_q    <= (CPHA && !pop_in_shift) ? 1'b0 : fifo_rdata_i[7];
            end else begin
                if (advance) begin
                    mosi_q <= shreg_q[7];
                end
                if (trail) begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end
        end
    end

    // Holds the bits not yet on MOSI; data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            shreg_q <= (CPHA && !pop_in_shift) ? fifo_rdata_i : {fifo_rdata_i[6:0], 1'b0};
        end else if (advance) begin
            shreg_q <= {shreg_q[6:0], 1'b0};
        end
    end

    assign spi_cs_o      = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign spi_mosi_o    = (state_q == ST_IDLE) ? 1'b0 : mosi_q;
    // Gated so the strobe is low for the whole time reset is asserted.
    assign fifo_rready_o = pop && rst_ni;

endmodule
